// File: rtl/ser2par_pkg.sv
// Shared types and defaults for the serial-to-parallel converter.
package ser2par_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_e;

    localparam int unsigned DEF_WIDTH = 8;

endpackage

// File: rtl/ser2par_cnt.sv
// Bit counter for one serial word: advances on en_i, clr_i wins, tc_o flags count == WIDTH-1.
// Registered count, combinational terminal flag; no backpressure.
module ser2par_cnt
    import ser2par_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/ser2par.sv
// Serial-to-parallel word assembler; word is presented on the edge sampling its last bit (SER2PAR_PARITY_EN adds a trailing even-parity bit).
// A held output word is never overwritten: a word completing while out_valid=1 and out_ready=0 is dropped with an overflow pulse.
module ser2par
    import ser2par_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic             en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             parity_err
);

    state_e           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic             overflow_q;
    logic             tc;
    logic             cnt_en;
    logic             cnt_clr;
    logic             word_done;
    logic [WIDTH-1:0] word_d;
`ifdef SER2PAR_PARITY_EN
    logic             parity_err_q;
    logic             perr_d;
`endif

    // The parity bit is never shifted in, so the counter idles in PAR.
    assign cnt_en  = en && (state_q != PAR) && !tc;
    assign cnt_clr = en && (state_q != PAR) && tc;

    ser2par_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (cnt_en),
        .clr_i (cnt_clr),
        .tc_o  (tc)
    );

    always_comb begin
        if (MSB_FIRST) begin
            shift_d = {shift_q[WIDTH-2:0], d};
        end else begin
            shift_d = {d, shift_q[WIDTH-1:1]};
        end
`ifdef SER2PAR_PARITY_EN
        word_done = en && (state_q == PAR);
        word_d    = shift_q;
        perr_d    = (^shift_q) != d;
`else
        word_done = cnt_clr;
        word_d    = shift_d;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
`ifdef SER2PAR_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            overflow_q <= 1'b0;
            if (en) begin
                case (state_q)
                    IDLE, SHIFT: begin
                        shift_q <= shift_d;
                        if (tc) begin
`ifdef SER2PAR_PARITY_EN
                            state_q <= PAR;
`else
                            state_q <= IDLE;
`endif
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
            // Same-edge acceptance frees the holding register for the new word.
            if (word_done) begin
                if (!out_valid_q || out_ready) begin
                    out_data_q   <= word_d;
                    out_valid_q  <= 1'b1;
`ifdef SER2PAR_PARITY_EN
                    parity_err_q <= perr_d;
`endif
                end else begin
                    overflow_q <= 1'b1;
                end
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
`ifdef SER2PAR_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ser2par.sv
// Randomised and directed bench for ser2par: an MSB-first and an LSB-first instance share one bit stream and are checked against a bit-queue model.
module tb_ser2par;

    localparam int W = 8;
`ifdef SER2PAR_PARITY_EN
    localparam int NEED = W + 1;
`else
    localparam int NEED = W;
`endif

    logic         clk;
    logic         rst;
    logic         d;
    logic         en;
    logic         out_ready;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ovf;
    logic         m_perr;
    logic [W-1:0] l_data;
    logic         l_valid;
    logic         l_ovf;
    logic         l_perr;

    int total = 0;
    int bad   = 0;

    ser2par #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .d(d), .en(en),
        .out_data(m_data), .out_valid(m_valid), .out_ready(out_ready),
        .overflow(m_ovf), .parity_err(m_perr)
    );

    ser2par #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .d(d), .en(en),
        .out_data(l_data), .out_valid(l_valid), .out_ready(out_ready),
        .overflow(l_ovf), .parity_err(l_perr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: bits since the last word boundary kept as a list.
    bit           bq[$];
    logic [W-1:0] e_dm = '0;
    logic [W-1:0] e_dl = '0;
    logic         e_v  = 1'b0;
    logic         e_o  = 1'b0;
    logic         e_p  = 1'b0;

    always @(posedge clk or negedge rst) begin
        bit           done;
        logic [W-1:0] wm;
        logic [W-1:0] wl;
        logic         pe;
        if (!rst) begin
            bq.delete();
            e_dm = '0;
            e_dl = '0;
            e_v  = 1'b0;
            e_o  = 1'b0;
            e_p  = 1'b0;
        end else begin
            done = 1'b0;
            pe   = 1'b0;
            wm   = '0;
            wl   = '0;
            if (en) begin
                bq.push_back(d);
                if (bq.size() == NEED) begin
                    for (int i = 0; i < W; i++) begin
                        wm[W-1-i] = bq[i];
                        wl[i]     = bq[i];
                    end
`ifdef SER2PAR_PARITY_EN
                    pe = ((^wm) != bq[W]);
`endif
                    bq.delete();
                    done = 1'b1;
                end
            end
            e_o = 1'b0;
            if (done) begin
                if (!e_v || out_ready) begin
                    e_dm = wm;
                    e_dl = wl;
                    e_v  = 1'b1;
                    e_p  = pe;
                end else begin
                    e_o = 1'b1;
                end
            end else if (e_v && out_ready) begin
                e_v = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_valid", 32'(m_valid), 32'(e_v));
        chk("l_valid", 32'(l_valid), 32'(e_v));
        chk("m_ovf",   32'(m_ovf),   32'(e_o));
        chk("l_ovf",   32'(l_ovf),   32'(e_o));
        chk("m_data",  32'(m_data),  32'(e_dm));
        chk("l_data",  32'(l_data),  32'(e_dl));
        if (e_v) begin
            chk("m_perr", 32'(m_perr), 32'(e_p));
            chk("l_perr", 32'(l_perr), 32'(e_p));
        end
    end

    // Inputs change 1 time unit after a rising edge and are sampled at the next.
    task automatic step(input logic e, input logic b, input logic r);
        en        = e;
        d         = b;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit lsb_first, input logic r,
                             input logic r_last, input int gap_min, input int gap_max,
                             input bit flip_par);
        logic b;
        for (int i = 0; i < NEED; i++) begin
            if (i > 0) begin
                int g;
                g = int'($urandom_range(gap_max, gap_min));
                for (int k = 0; k < g; k++) step(1'b0, 1'($urandom_range(1, 0)), r);
            end
            if (i == W) b = (^w) ^ flip_par;
            else        b = lsb_first ? w[i] : w[W-1-i];
            step(1'b1, b, (i == NEED - 1) ? r_last : r);
        end
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'($urandom_range(1, 0)), 1'b0);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; d = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(m_valid), 32'h0);
        chk("rst_data",  32'(m_data),  32'h0);
        chk("rst_ovf",   32'(m_ovf),   32'h0);
        chk("rst_perr",  32'(m_perr),  32'h0);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b1);

        // Back-to-back bits, ready high.
        send_word(8'hA5, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
        chk("a5_valid", 32'(m_valid), 32'h1);
        chk("a5_data",  32'(m_data),  32'hA5);
        step(1'b0, 1'b0, 1'b1);
        chk("a5_drop",  32'(m_valid), 32'h0);

        // en gaps of 1..3 cycles between bits.
        send_word(8'h3C, 1'b0, 1'b1, 1'b1, 1, 3, 1'b0);
        chk("3c_data",  32'(m_data),  32'h3C);
        step(1'b0, 1'b0, 1'b1);

        // Overflow: second word arrives while first is still held.
        send_word(8'h11, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0);
        chk("11_data",  32'(m_data),  32'h11);
        send_word(8'h22, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0);
        chk("ovf_pulse", 32'(m_ovf),  32'h1);
        chk("ovf_keep",  32'(m_data), 32'h11);
        step(1'b0, 1'b0, 1'b0);
        chk("ovf_once",  32'(m_ovf),  32'h0);
        chk("ovf_hold",  32'(m_valid), 32'h1);
        step(1'b0, 1'b0, 1'b1);
        chk("ovf_drain", 32'(m_valid), 32'h0);
        chk("ovf_ret",   32'(m_data), 32'h11);

        // Same-edge accept and replace.
        send_word(8'h11, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
        chk("swap_valid", 32'(m_valid), 32'h1);
        chk("swap_data",  32'(m_data),  32'h22);
        chk("swap_ovf",   32'(m_ovf),   32'h0);
        step(1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-word with a word pending.
        send_word(8'h55, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        send_bits(4);
        #1 rst = 1'b0;
        #1;
        chk("arst_valid", 32'(m_valid), 32'h0);
        chk("arst_data",  32'(m_data),  32'h0);
        chk("arst_ldata", 32'(l_data),  32'h0);
        chk("arst_ovf",   32'(m_ovf),   32'h0);
        #1 rst = 1'b1;
        send_word(8'hF0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
        chk("f0_data",  32'(m_data),  32'hF0);
        chk("f0_valid", 32'(m_valid), 32'h1);
        step(1'b0, 1'b0, 1'b1);

        // LSB-first stream lands unreversed in the LSB-first instance.
        send_word(8'hA5, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0);
        chk("lsb_data", 32'(l_data), 32'hA5);
        step(1'b0, 1'b0, 1'b1);
        send_word(8'h0F, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0);
        chk("lsb_0f",   32'(l_data), 32'h0F);
        chk("msb_f0",   32'(m_data), 32'hF0);
        step(1'b0, 1'b0, 1'b1);

`ifdef SER2PAR_PARITY_EN
        send_word(8'hA5, 1'b0, 1'b1, 1'b1, 0, 0, 1'b1);
        chk("par_bad",  32'(m_perr), 32'h1);
        step(1'b0, 1'b0, 1'b1);
        send_word(8'hA5, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
        chk("par_good", 32'(m_perr), 32'h0);
        step(1'b0, 1'b0, 1'b1);
`endif

        for (int n = 0; n < 2000; n++) begin
            step(1'($urandom_range(99, 0) < 60), 1'($urandom_range(1, 0)),
                 1'($urandom_range(99, 0) < 35));
            if ($urandom_range(199, 0) == 0) begin
                #2 rst = 1'b0;
                #1 rst = 1'b1;
            end
        end
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
